// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core width and memory-port arbiter state encoding.
package riscv_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_D} arb_state_e;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, data first with fetch starvation guard.
// The cycle a valid pulses is a turnaround: no grant, so the served requester can update its held request.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic            if_valid,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_stall,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_be,
  output logic            d_valid,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  arb_state_e      state_q, grant_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            kill_q, mem_req_q, mem_we_q, if_valid_q, d_valid_q;
  logic [XLEN-1:0] mem_addr_q, mem_wdata_q, if_rdata_q, d_rdata_q;
  logic [3:0]      mem_be_q;
  logic            turn, if_ok, d_ok, starved, done;
  function automatic arb_state_e arbitrate(input logic f_ok, input logic dat_ok, input logic f_starved);
    return (f_ok && (f_starved || !dat_ok)) ? SERVE_IF : dat_ok ? SERVE_D : IDLE;
  endfunction
  assign turn     = if_valid_q | d_valid_q;
  assign if_ok    = if_req & ~if_flush & ~turn;
  assign d_ok     = d_req & ~turn;
  assign starved  = starve_q == SW'(STARVE_LIMIT);
  assign done     = mem_req_q & mem_ready;
  assign grant_d  = (state_q == IDLE) ? arbitrate(if_ok, d_ok, starved) : IDLE;
  assign starve_d = (!if_req || grant_d == SERVE_IF) ? '0 :
                    (grant_d == SERVE_D && !starved) ? starve_q + SW'(1) : starve_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      kill_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      starve_q   <= starve_d;
      if_valid_q <= done && state_q == SERVE_IF && !(kill_q || if_flush);
      d_valid_q  <= done && state_q == SERVE_D;
      if (state_q == IDLE) begin
        if (grant_d != IDLE) begin
          state_q     <= grant_d;
          mem_req_q   <= 1'b1;
          mem_we_q    <= grant_d == SERVE_D && d_we;
          mem_addr_q  <= grant_d == SERVE_D ? d_addr : if_addr;
          mem_wdata_q <= grant_d == SERVE_D ? d_wdata : '0;
          mem_be_q    <= grant_d == SERVE_D ? d_be : 4'hf;
          kill_q      <= 1'b0;
        end
      end else if (done) begin
        state_q   <= IDLE;
        mem_req_q <= 1'b0;
        kill_q    <= 1'b0;
        if (state_q == SERVE_IF) if_rdata_q <= mem_rdata;
        else d_rdata_q <= mem_rdata;
      end else begin
        // A redirect mid-fetch lets memory finish but hides the stale instruction.
        kill_q <= kill_q | (state_q == SERVE_IF && if_flush);
      end
    end
  end
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign d_stall   = d_req & ~d_valid_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboarded bench with a variable-latency memory responder.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 0, if_flush = 0, d_req = 0, d_we = 0, mem_ready = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [3:0]  d_be = 0;
  logic        if_valid, if_stall, d_valid, d_stall, mem_req, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  int n_tests = 0, n_fail = 0, if_cnt = 0, d_cnt = 0, mem_done = 0, mem_delay = 0, wcnt = 0;
  logic [31:0] if_q[$], d_q[$], grant_log[$];
  logic [67:0] wr_exp[$];
  logic [68:0] snap;
  logic        stable;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall), .d_req(d_req),
    .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be), .d_valid(d_valid),
    .d_rdata(d_rdata), .d_stall(d_stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [67:0] act, input logic [67:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst || !mem_req) begin
      wcnt = 0;
      mem_ready = 1'b0;
    end else begin
      if (wcnt == 0) begin
        snap = {mem_we, mem_addr, mem_wdata, mem_be};
        stable = 1'b1;
        grant_log.push_back(mem_addr);
      end else if ({mem_we, mem_addr, mem_wdata, mem_be} !== snap) stable = 1'b0;
      mem_ready = wcnt >= mem_delay;
      wcnt++;
      if (mem_ready) begin
        mem_rdata = mem_word(mem_addr);
        mem_done++;
        chk("mem_stable", stable, 1);
        if (mem_we) begin
          if (wr_exp.size() == 0) chk("wr_unexp", 1, 0);
          else chk("wr_cmd", {mem_addr, mem_wdata, mem_be}, wr_exp.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (if_valid) begin
      if_cnt++;
      if (if_q.size() == 0) chk("if_unexp", 1, 0);
      else chk("if_rdata", if_rdata, if_q.pop_front());
    end
    if (d_valid) begin
      d_cnt++;
      if (d_q.size() == 0) chk("d_unexp", 1, 0);
      else chk("d_rdata", d_rdata, d_q.pop_front());
    end
  end

  task automatic wait_fetch(output int lat);
    logic got = 0, st_ok = 1;
    lat = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = if_valid;
      if (!got && !if_stall) st_ok = 0;
    end
    chk("if_valid_seen", got, 1);
    chk("if_stall_wait", st_ok, 1);
    chk("if_stall_done", if_stall, 0);
    @(posedge clk);
    #1 if_req = 0;
  endtask

  task automatic do_fetch(input logic [31:0] a, output int lat);
    if_addr = a;
    if_req = 1;
    if_q.push_back(mem_word(a));
    wait_fetch(lat);
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    logic got = 0, st_ok = 1;
    d_we = we; d_addr = a; d_wdata = wd; d_be = be; d_req = 1;
    d_q.push_back(mem_word(a));
    if (we) wr_exp.push_back({a, wd, be});
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      got = d_valid;
      if (!got && !d_stall) st_ok = 0;
    end
    chk("d_valid_seen", got, 1);
    chk("d_stall_wait", st_ok, 1);
    chk("d_stall_done", d_stall, 0);
    @(posedge clk);
    #1 d_req = 0;
  endtask

  task automatic wait_mem_req();
    logic got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = mem_req;
    end
    chk("mem_req_seen", got, 1);
  endtask

  task automatic chk_grants(input string tag, input logic [31:0] exp[$]);
    chk({tag, "_n"}, grant_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < grant_log.size(); i++) chk(tag, grant_log[i], exp[i]);
    grant_log.delete();
  endtask

  initial begin
    int lat, ic, dc, md;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_cmd", {mem_addr, mem_wdata, mem_be}, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    chk("rst_stall", {if_stall, d_stall}, 0);
    @(posedge clk);
    #1;
    do_fetch(32'h100, lat);
    chk("if_latency", lat, 3);
    repeat (3) @(negedge clk);
    chk("if_hold", if_rdata, 32'h0050_0093);
    chk_grants("g_single", '{32'h100});
    @(posedge clk);
    #1;
    fork
      do_fetch(32'h200, lat);
      do_data(0, 32'h300, 0, 4'hf);
    join
    chk_grants("g_simul", '{32'h300, 32'h200});
    chk("simul_cnt", {if_cnt, d_cnt}, {32'd2, 32'd1});
    fork
      for (int i = 0; i < 6; i++) do_data(0, 32'h400 + 4 * i, 0, 4'hf);
      for (int i = 0; i < 2; i++) do_fetch(32'h800 + 4 * i, lat);
    join
    chk_grants("g_starve", '{32'h400, 32'h404, 32'h408, 32'h40c, 32'h800, 32'h410, 32'h414, 32'h804});
    mem_delay = 3;
    ic = if_cnt;
    md = mem_done;
    if_addr = 32'h900;
    if_req = 1;
    wait_mem_req();
    @(posedge clk);
    #1 if_flush = 1;
    @(posedge clk);
    #1 if_flush = 0;
    if_addr = 32'h904;
    if_q.push_back(mem_word(32'h904));
    wait_fetch(lat);
    chk("flush_if_cnt", if_cnt - ic, 1);
    chk("flush_mem_done", mem_done - md, 2);
    chk_grants("g_flush", '{32'h900, 32'h904});
    mem_delay = 2;
    do_data(1, 32'h500, 32'hdead_beef, 4'b0011);
    chk_grants("g_write", '{32'h500});
    mem_delay = 5;
    dc = d_cnt;
    d_we = 0; d_addr = 32'h600; d_req = 1;
    wait_mem_req();
    @(posedge clk);
    #1 rst = 1;
    d_req = 0;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_d_valid", d_valid, 0);
    repeat (6) @(negedge clk);
    chk("rstmid_no_valid", d_cnt - dc, 0);
    chk("rstmid_idle", mem_req, 0);
    grant_log.delete();
    mem_delay = 0;
    @(posedge clk);
    #1;
    do_fetch(32'h104, lat);
    chk("post_rst_lat", lat, 3);
    chk("end_if_q", if_q.size(), 0);
    chk("end_d_q", d_q.size(), 0);
    chk("end_wr_q", wr_exp.size(), 0);
    chk("end_counts", {if_cnt, d_cnt}, {32'd6, 32'd8});
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the maximum consecutive data grants allowed while a fetch is pending.
REQ-002 clk  in  1  clock; all state SHALL update on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 if_req  in  1  fetch request, held high until if_valid.
REQ-005 if_addr  in  XLEN  fetch address.
REQ-006 if_flush  in  1  control-flow redirect; the pending or in-flight fetch is discarded.
REQ-007 if_valid  out  1  one-cycle pulse; if_rdata valid.
REQ-008 if_rdata  out  XLEN  fetched instruction.
REQ-009 d_req  in  1  data request, held high until d_valid.
REQ-010 d_we  in  1  data write enable.
REQ-011 d_addr / d_wdata  in  XLEN  data address / write data.
REQ-012 d_be  in  4  byte enables.
REQ-013 d_valid  out  1  one-cycle completion pulse for reads and writes.
REQ-014 d_rdata  out  XLEN  load data.
REQ-015 if_stall / d_stall  out  1  each equals its req AND NOT its valid, combinational.
REQ-016 mem_req  out  1  memory request, held until mem_ready.
REQ-017 mem_we, mem_addr, mem_wdata, mem_be  out  1/XLEN/XLEN/4  registered memory command.
REQ-018 mem_ready  in  1  memory accepts and completes; mem_rdata valid in the same cycle.
REQ-019 mem_rdata  in  XLEN  memory read data.

Function
REQ-020 FSM states SHALL be IDLE, SERVE_IF and SERVE_D.
REQ-021 In IDLE, the FSM SHALL grant exactly one eligible requester.
- Grant SHALL latch owner, address, write data, byte enables and we into command registers.
- Grant SHALL move the FSM to SERVE_IF or SERVE_D.
REQ-022 Priority SHALL be data over fetch, except when starve_cnt equals STARVE_LIMIT and fetch is eligible; then fetch wins.
REQ-023 starve_cnt SHALL increment on each data grant while if_req is high.
- It SHALL saturate at STARVE_LIMIT.
- It SHALL clear on a fetch grant or in any cycle where if_req is low.
REQ-024 In SERVE_x, mem_req SHALL be 1 with stable command registers until mem_ready.
- On mem_ready, mem_rdata SHALL be registered into the owner's rdata register.
- On mem_ready, the FSM SHALL return to IDLE.
REQ-025 The owner's valid SHALL pulse for exactly one cycle, the cycle after mem_ready.
- Minimum latency: req at cycle N, mem_req at N+1, mem_ready at N+1, valid at N+2.
REQ-026 A requester whose valid is asserted in the current cycle SHALL NOT be eligible for grant in that cycle, preventing double service of a held req.
REQ-027 if_flush with if_req in IDLE SHALL make fetch ineligible for that cycle.
REQ-028 if_flush during SERVE_IF SHALL set a kill flag.
- The memory transaction SHALL complete normally.
- if_valid SHALL be suppressed, and the kill flag SHALL clear at completion.
REQ-029 if_flush SHALL have no effect on data transactions.
REQ-030 mem_req SHALL be 0 in IDLE, so no command reaches memory without a grant.
REQ-031 if_rdata and d_rdata SHALL hold their last captured value between pulses.

Reset
REQ-032 rst SHALL set the FSM to IDLE and clear starve_cnt and the kill flag.
REQ-033 rst SHALL drive mem_req, mem_we, if_valid and d_valid to 0.
REQ-034 rst SHALL set mem_addr, mem_wdata, mem_be, if_rdata and d_rdata to 0.
REQ-035 rst during SERVE_x SHALL abandon the transaction with no valid pulse; the memory model is reset concurrently.

Structure
REQ-036 The arbiter state enum (IDLE, SERVE_IF, SERVE_D) SHALL live in riscv_pkg.
REQ-037 XLEN SHALL be taken from riscv_pkg.
REQ-038 The design SHALL be a single module with no sub-modules; the arbitration function SHALL be a local automatic function.

Verification
REQ-039 Single fetch: if_req=1, if_addr=0x100, mem_ready immediate, mem_rdata=0x00500093 -> if_valid at N+2, if_rdata=0x00500093.
REQ-040 Simultaneous requests: if_req and d_req rise together -> SERVE_D first (d_addr on mem_addr), then SERVE_IF; each valid pulses once.
REQ-041 Starvation: d_req held continuously, if_req held, STARVE_LIMIT=4 -> 4 data grants, then a fetch grant, then data resumes.
REQ-042 Flush in flight: if_flush during SERVE_IF with mem_ready delayed 3 cycles -> mem completes, no if_valid, next fetch granted normally.
REQ-043 Write with stall: d_we=1, d_be=0b0011, d_wdata=0xDEADBEEF, mem_ready delayed 2 cycles -> mem_* stable throughout, d_stall=1 until d_valid.
REQ-044 Reset mid-transaction: rst during SERVE_D -> next cycle IDLE, mem_req=0, no d_valid.
